// File: rtl/usb_rx_packer.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_packer
// Description : Reads bytes from an async USB FIFO with a timed active-low
//               rd strobe and packs them little-endian into words queued in
//               a small output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_packer #(
    parameter int WORD_BYTES = 2,
    parameter int DEPTH      = 4,
    parameter int RD_WAIT    = 2,
    parameter int RD_RECOVER = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                data,
    input  logic                      rxf,
    output logic                      rd,
    input  logic                      hold,
    input  logic                      flush,
    output logic [8*WORD_BYTES-1:0]   out_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fill,
    output logic [8*WORD_BYTES-1:0]   last_word,
    output logic [1:0]                state
);

    localparam int c_W       = 8 * WORD_BYTES;
    localparam int c_IDX_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_MAX = (RD_WAIT > RD_RECOVER) ? RD_WAIT : RD_RECOVER;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_LOW  = 2'd1;
    localparam logic [1:0] c_RD_HIGH = 2'd2;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(WORD_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(RD_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_REC_LAST  = c_CNT_W'(RD_RECOVER - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH     = (c_PTR_W + 1)'(DEPTH);

    logic [1:0]         r_state;
    logic               r_rd;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_byte_idx;
    logic [c_W-1:0]     r_asm;
    logic [c_W-1:0]     r_last;
    logic [c_W-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_fill;

    logic               w_start;
    logic               w_latch;
    logic               w_push;
    logic               w_pop;
    logic [c_W-1:0]     w_word;

    assign w_start = (r_state == c_IDLE) && !rxf && !hold && (r_fill < c_DEPTH);
    assign w_latch = (r_state == c_RD_LOW) && (r_cnt == c_WAIT_LAST);
    // A byte landing together with flush is dropped, so it can never complete a word.
    assign w_push  = w_latch && !flush && (r_byte_idx == c_LAST_IDX);
    assign w_pop   = (r_fill != '0) && out_ready;

    always_comb begin
        w_word              = r_asm;
        w_word[c_W-8 +: 8]  = data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_rd    <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state <= c_RD_LOW;
                        r_rd    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                c_RD_LOW: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_state <= c_RD_HIGH;
                        r_rd    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RD_HIGH: begin
                    if (r_cnt == c_REC_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_rd    <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_last     <= '0;
        end else if (flush) begin
            r_byte_idx <= '0;
        end else if (w_latch) begin
            r_asm[{r_byte_idx, 3'b000} +: 8] <= data;
            if (r_byte_idx == c_LAST_IDX) begin
                r_byte_idx <= '0;
                r_last     <= w_word;
            end else begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd        = r_rd;
    assign state     = r_state;
    assign out_word  = r_mem[r_rd_ptr];
    assign out_valid = (r_fill != '0);
    assign fill      = r_fill;
    assign last_word = r_last;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_packer
// Description : Scoreboard bench for usb_rx_packer with a byte-source model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_packer;

    localparam int WB         = 2;
    localparam int DEPTH      = 4;
    localparam int RD_WAIT    = 2;
    localparam int RD_RECOVER = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data  = 8'h00;
    logic        rxf   = 1'b1;
    logic        hold  = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        rd;
    logic        out_valid;
    logic [15:0] out_word;
    logic [15:0] last_word;
    logic [2:0]  fill;
    logic [1:0]  state;

    usb_rx_packer #(
        .WORD_BYTES(WB), .DEPTH(DEPTH), .RD_WAIT(RD_WAIT), .RD_RECOVER(RD_RECOVER)
    ) dut (
        .clock(clock), .reset(reset), .data(data), .rxf(rxf), .rd(rd),
        .hold(hold), .flush(flush), .out_word(out_word), .out_valid(out_valid),
        .out_ready(out_ready), .fill(fill), .last_word(last_word), .state(state)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  src[$];
    logic [15:0] exp_q[$];
    logic [7:0]  pend[$];
    logic [15:0] m_last = '0;
    bit          rxf_block = 1'b0;
    int          lo_run = 0;
    int          hi_run = 100;
    logic        prev_rd = 1'b1;
    bit          s_reset = 1'b1, s_flush = 1'b0, s_hold = 1'b0, s_rxf = 1'b1;
    bit          s_idle = 1'b1;
    int          s_fill = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // Input values as seen by the DUT at each active edge.
    always @(posedge clock) begin
        s_reset = reset;
        s_flush = flush;
        s_hold  = hold;
        s_rxf   = rxf;
    end

    // Reference model + scoreboard, evaluated between edges.
    always @(negedge clock) begin : monitor
        logic [7:0]  b;
        logic [15:0] w;
        bit          fell;
        bit          exp_fell;
        int          exp_state;
        fell = prev_rd && !rd;
        if (s_reset) begin
            exp_q.delete();
            pend.delete();
            m_last = '0;
            hi_run = 100;
            check("reset_rd", rd, 1);
        end else begin
            exp_fell = s_idle && !s_rxf && !s_hold && (s_fill < DEPTH);
            check("read_start", fell, exp_fell);
            if (!prev_rd && rd) begin
                check("rd_low_cycles", lo_run, RD_WAIT);
                if (src.size() == 0) begin
                    fail("src_underflow", "got a read, expected none (no byte offered)");
                    b = 8'h00;
                end else begin
                    b = src.pop_front();
                end
                if (s_flush) begin
                    pend.delete();
                end else begin
                    pend.push_back(b);
                    if (pend.size() == WB) begin
                        w = '0;
                        for (int k = 0; k < WB; k++) w[8*k +: 8] = pend[k];
                        exp_q.push_back(w);
                        m_last = w;
                        pend.delete();
                    end
                end
                hi_run = 1;
            end else begin
                if (s_flush) pend.delete();
                if (!rd) lo_run = fell ? 1 : lo_run + 1;
                else if (hi_run < 100) hi_run++;
            end
        end
        exp_state = !rd ? 1 : ((hi_run <= RD_RECOVER) ? 2 : 0);
        check("state", state, exp_state);
        check("fill", fill, exp_q.size());
        check("out_valid", out_valid, exp_q.size() != 0);
        check("last_word", last_word, m_last);
        s_fill = exp_q.size();
        s_idle = rd && (hi_run > RD_RECOVER);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail("out_word", "got a word, expected none");
            else check("out_word", out_word, exp_q.pop_front());
        end
        prev_rd = rd;
        data = (src.size() != 0) ? src[0] : 8'h00;
        rxf  = (src.size() == 0) || rxf_block;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int lim);
        int i;
        i = 0;
        while (!out_valid && i < lim) begin
            @(negedge clock);
            i++;
        end
        if (!out_valid) fail("timeout_valid", "got out_valid=0, expected 1");
    endtask

    initial begin
        int n;
        int sz;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_out_word", out_word, 0);
        check("rst_last_word", last_word, 0);
        check("rst_rd", rd, 1);
        check("rst_fill", fill, 0);

        // Basic two-byte word
        step();
        src.push_back(8'h34);
        src.push_back(8'h12);
        wait_valid(100);
        check("t1_out_word", out_word, 16'h1234);
        check("t1_last_word", last_word, 16'h1234);
        step(); out_ready = 1'b1;
        step(); out_ready = 1'b0;

        // Backpressure: FIFO fills, exactly one word of room reopens after one pop
        for (int i = 0; i < 10; i++) src.push_back(8'($urandom));
        repeat (80) @(posedge clock);
        @(negedge clock); #1;
        check("full_fill", fill, 4);
        check("full_bytes_left", src.size(), 2);
        check("full_rd", rd, 1);
        step(); out_ready = 1'b1;
        step(); out_ready = 1'b0;
        repeat (30) @(posedge clock);
        @(negedge clock); #1;
        check("refill_fill", fill, 4);
        check("refill_bytes_left", src.size(), 0);
        step(); out_ready = 1'b1;
        repeat (8) @(posedge clock);
        @(negedge clock); #1;
        check("drained_fill", fill, 0);

        // Hold blocks starts only
        step();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) src.push_back(8'($urandom));
        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (!rd) n++;
        end
        check("hold_rd_low_cycles", n, 0);
        step(); hold = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (rd && n < 6);
        check("hold_release_fast", (n <= 2) && !rd, 1);
        #1;
        sz = src.size();
        hold = 1'b1;
        n = 0;
        while (!rd && n < 10) begin
            @(negedge clock);
            n++;
        end
        #1;
        check("hold_mid_read_done", src.size(), sz - 1);
        repeat (10) @(posedge clock);
        @(negedge clock); #1;
        check("hold_no_new_read", src.size(), sz - 1);
        step(); hold = 1'b0;
        repeat (40) @(posedge clock);

        // Flush discards a partial word
        step();
        src.push_back(8'hAA);
        n = 0;
        while (src.size() != 0 && n < 40) begin
            @(negedge clock); #1;
            n++;
        end
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        src.push_back(8'h01);
        src.push_back(8'h02);
        repeat (20) @(posedge clock);
        @(negedge clock); #1;
        check("flush_last_word", last_word, 16'h0201);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            rxf_block = ($urandom_range(0, 7) == 0);
            if (src.size() < 3 && $urandom_range(0, 1) == 1) src.push_back(8'($urandom));
        end
        step();
        hold = 1'b0; reset = 1'b0; rxf_block = 1'b0; out_ready = 1'b1; flush = 1'b1;
        step(); flush = 1'b0;
        repeat (40) @(posedge clock);

        // Reset in the middle of a read
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
        n = 0;
        @(negedge clock);
        while (!(fill == 3'd2 && !rd) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!(fill == 3'd2 && !rd)) fail("timeout_rd_low", "got no read at fill=2, expected one");
        #1 reset = 1'b1;
        @(negedge clock);
        check("midrst_rd", rd, 1);
        check("midrst_fill", fill, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_state", state, 0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        repeat (60) @(posedge clock);
        @(negedge clock); #1;
        check("final_fill", fill, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected one before 500us");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/usb_rx_packer.md
USB_RX_PACKER -- requirements
Module: usb_rx_packer

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 2: bytes per output word, legal range 1..8.
REQ-002 The block SHALL have parameter DEPTH, default 4: output FIFO depth in words, a power of 2, at least 2.
REQ-003 The block SHALL have parameter RD_WAIT, default 2: cycles rd is held low per byte read, at least 1.
REQ-004 The block SHALL have parameter RD_RECOVER, default 1: cycles rd is held high after each read, at least 1.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: port clock (input, 1 bit, sole clock, all logic on posedge) and port reset (input, 1 bit).
REQ-006 The block SHALL have port data, input, 8 bits: USB FIFO data pins.
REQ-007 The block SHALL have port rxf, input, 1 bit: USB FIFO rxf, active low, 0 means a byte is available.
REQ-008 The block SHALL have port rd, output, 1 bit: USB FIFO read strobe, active low.
REQ-009 The block SHALL have port hold, input, 1 bit: 1 blocks the start of new reads.
REQ-010 The block SHALL have port flush, input, 1 bit: 1 discards the partially assembled word.
REQ-011 The block SHALL have port out_word, output, 8*WORD_BYTES bits: FIFO head word.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_word.
REQ-014 The block SHALL have port fill, output, $clog2(DEPTH)+1 bits: words currently in the FIFO.
REQ-015 The block SHALL have port last_word, output, 8*WORD_BYTES bits: most recently pushed word, for the hex display.
REQ-016 The block SHALL have port state, output, 2 bits: FSM state, for debug.

Function
REQ-017 FSM states SHALL be IDLE=0, RD_LOW=1, RD_HIGH=2.
REQ-018 From IDLE, the FSM SHALL go to RD_LOW and drive rd=0 next cycle only when all of these hold: rxf==0, hold==0, fill<DEPTH.
REQ-019 rd SHALL stay 0 for exactly RD_WAIT cycles.
REQ-020 On the last RD_LOW cycle, the block SHALL latch data into assembly byte lane byte_idx and go to RD_HIGH with rd=1.
REQ-021 The FSM SHALL stay in RD_HIGH for exactly RD_RECOVER cycles, then return to IDLE.
REQ-022 rd SHALL be 1 in IDLE and RD_HIGH.
REQ-023 Lane packing SHALL be little-endian: byte k of a word goes to bits [8k+7:8k]; the first byte received is the LSB.
REQ-024 When the byte latched has byte_idx==WORD_BYTES-1, the complete word SHALL be pushed to the FIFO in that same cycle, last_word updated, and byte_idx reset to 0; otherwise byte_idx SHALL increment.
REQ-025 A pushed word SHALL appear as out_valid=1 on the next cycle when the FIFO was empty.
REQ-026 A pop SHALL occur when out_valid and out_ready are both 1; out_word SHALL advance next cycle.
REQ-027 Simultaneous push and pop SHALL leave fill unchanged and preserve word order.
REQ-028 The FIFO SHALL never overflow, because reads start only at fill<DEPTH and each read pushes at most one word.
REQ-029 A pop with fill==0 is impossible by construction, since out_valid=0.
REQ-030 hold or rxf rising mid-read SHALL NOT abort the read; the current byte SHALL complete, and only new starts are blocked.
REQ-031 flush=1 in any state SHALL clear byte_idx to 0 next cycle.
REQ-032 A byte latched in the same cycle as flush SHALL be discarded and SHALL NOT push a word.
REQ-033 flush SHALL NOT alter FIFO contents or the read timing.
REQ-034 fill SHALL equal pushes minus pops exactly, with range 0..DEPTH.
REQ-035 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-036 On reset=1, next cycle: rd=1, state=IDLE, byte_idx=0, fill=0, out_valid=0, out_word=0, last_word=0, assembly register=0.
REQ-037 Reset mid-read SHALL abort the read (rd=1 next cycle); FIFO contents SHALL be lost.
REQ-038 Reset SHALL override flush, hold and out_ready.

Verification (WORD_BYTES=2, DEPTH=4, RD_WAIT=2, RD_RECOVER=1)
REQ-039 rxf=0 supplying 0x34 then 0x12 -> out_word=0x1234, out_valid=1 one cycle after the second latch, last_word=0x1234.
REQ-040 rd waveform: rd low exactly 2 cycles per byte, high at least 1 cycle between consecutive reads; state sequence 0->1->1->2->0.
REQ-041 out_ready=0, rxf held 0 with 10 bytes -> exactly 8 bytes read, fill=4, rd stays 1; one pop -> exactly 2 more reads and fill=4 again; drained words in order.
REQ-042 hold=1 with rxf=0 -> rd stays 1 for 20 cycles; release hold -> rd falls within 2 cycles; hold raised during RD_LOW -> that byte still completes.
REQ-043 Byte 0xAA read, then flush pulse, then 0x01, 0x02 -> single word 0x0201; 0xAA never output.
REQ-044 Reset asserted in RD_LOW with fill=2 -> next cycle rd=1, fill=0, out_valid=0, state=0.
